// File: rtl/writeback_stage.sv
// writeback_stage: registered MEM/WB latch feeding the register-file write port.
// The result is selected from link PC+4, the (optionally extracted) load value or
// the ALU result at capture time and held in the latch.  A one-shot "fresh" flag
// gives exactly one write strobe per captured entry, however long the hold lasts.
// Writes to $0 and faulting (misaligned) loads are suppressed; a retire counter
// counts every captured, non-faulting entry.
// Optional build macro: WB_SUBWORD_EN enables byte/halfword load extraction with
// sign/zero extension (requires DATA_W == 32).  Without it every load is a full word.
module writeback_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  ivalid,
    input  logic                  ihold,
    input  logic                  iflush,
    input  logic                  iSig_regfile_write,
    input  logic                  iSig_MemtoReg,
    input  logic                  iSig_Link,
    input  logic [1:0]            iload_size,
    input  logic                  iload_unsigned,
    input  logic [REG_ADDR_W-1:0] iwrite_reg,
    input  logic [DATA_W-1:0]     iread_from_ram,
    input  logic [DATA_W-1:0]     ialu_result,
    input  logic [DATA_W-1:0]     ipc_plus4,
    output logic                  oready,
    output logic                  oregfile_we,
    output logic [REG_ADDR_W-1:0] owrite_reg,
    output logic [DATA_W-1:0]     odata2write2regfile,
    output logic                  omisaligned,
    output logic [CNT_W-1:0]      oretired
);

    logic                  valid_q, valid_d;
    logic                  fresh_q, fresh_d;
    logic                  regwrite_q, regwrite_d;
    logic                  misaligned_q, misaligned_d;
    logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [CNT_W-1:0]      retired_q, retired_d;

    logic [DATA_W-1:0]     load_val;
    logic                  misaligned_in;
    logic                  capture;

`ifdef WB_SUBWORD_EN
    generate
        if (DATA_W != 32) begin : g_bad_width
            $error("writeback_stage: WB_SUBWORD_EN requires DATA_W == 32");
        end
    endgenerate

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Little-endian lane extraction and sign/zero extension of sub-word loads.
    always_comb begin
        byte_lane = iread_from_ram[7:0];
        case (ialu_result[1:0])
            2'd0:    byte_lane = iread_from_ram[7:0];
            2'd1:    byte_lane = iread_from_ram[15:8];
            2'd2:    byte_lane = iread_from_ram[23:16];
            default: byte_lane = iread_from_ram[31:24];
        endcase
        half_lane = ialu_result[1] ? iread_from_ram[31:16] : iread_from_ram[15:0];
        case (iload_size)
            2'b00:   load_val = {{(DATA_W-8){~iload_unsigned & byte_lane[7]}}, byte_lane};
            2'b01:   load_val = {{(DATA_W-16){~iload_unsigned & half_lane[15]}}, half_lane};
            default: load_val = iread_from_ram;
        endcase
        misaligned_in = iSig_MemtoReg &
                        (((iload_size == 2'b01) & ialu_result[0]) |
                         (iload_size[1] & (ialu_result[1:0] != 2'b00)));
    end
`else
    logic unused_subword;

    // Full-word loads only; size and signedness controls have no effect.
    always_comb begin
        load_val       = iread_from_ram;
        misaligned_in  = iSig_MemtoReg & (ialu_result[1:0] != 2'b00);
        unused_subword = ^{iload_size, iload_unsigned};
    end
`endif

    assign capture = ivalid & ~ihold & ~iflush;

    // Next-state of the latch: flush beats hold, hold beats capture.
    always_comb begin
        valid_d      = valid_q;
        fresh_d      = fresh_q;
        regwrite_d   = regwrite_q;
        misaligned_d = misaligned_q;
        write_reg_d  = write_reg_q;
        data_d       = data_q;
        retired_d    = retired_q;
        if (iflush) begin
            valid_d = 1'b0;
            fresh_d = 1'b0;
        end else if (ihold) begin
            fresh_d = 1'b0;
        end else if (capture) begin
            valid_d      = 1'b1;
            fresh_d      = 1'b1;
            regwrite_d   = iSig_regfile_write;
            misaligned_d = misaligned_in;
            write_reg_d  = iwrite_reg;
            if (iSig_Link) begin
                data_d = ipc_plus4;
            end else if (iSig_MemtoReg) begin
                data_d = load_val;
            end else begin
                data_d = ialu_result;
            end
            if (!misaligned_in) begin
                retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            valid_d = 1'b0;
            fresh_d = 1'b0;
        end
    end

    // MEM/WB latch and retire counter; reset discards any entry in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q      <= 1'b0;
            fresh_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            misaligned_q <= 1'b0;
            write_reg_q  <= '0;
            data_q       <= '0;
            retired_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            fresh_q      <= fresh_d;
            regwrite_q   <= regwrite_d;
            misaligned_q <= misaligned_d;
            write_reg_q  <= write_reg_d;
            data_q       <= data_d;
            retired_q    <= retired_d;
        end
    end

    assign oready              = ~ihold;
    assign oregfile_we         = valid_q & fresh_q & regwrite_q &
                                 (write_reg_q != '0) & ~misaligned_q;
    assign owrite_reg          = write_reg_q;
    assign odata2write2regfile = data_q;
    assign omisaligned         = valid_q & misaligned_q;
    assign oretired            = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed and randomized checks of writeback_stage against an
// entry-level reference model (one record per latched instruction plus a count of
// whether its single register write has already been offered).
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ivalid, ihold, iflush;
    logic        iSig_regfile_write, iSig_MemtoReg, iSig_Link;
    logic [1:0]  iload_size;
    logic        iload_unsigned;
    logic [4:0]  iwrite_reg;
    logic [31:0] iread_from_ram, ialu_result, ipc_plus4;
    logic        oready, oregfile_we, omisaligned;
    logic [4:0]  owrite_reg;
    logic [31:0] odata2write2regfile, oretired;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: the entry currently in writeback
    bit          m_valid;
    int          m_writes_left;
    bit          m_wr, m_mis;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic [31:0] m_retired;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk                 (clk),
        .rstn                (rstn),
        .ivalid              (ivalid),
        .ihold               (ihold),
        .iflush              (iflush),
        .iSig_regfile_write  (iSig_regfile_write),
        .iSig_MemtoReg       (iSig_MemtoReg),
        .iSig_Link           (iSig_Link),
        .iload_size          (iload_size),
        .iload_unsigned      (iload_unsigned),
        .iwrite_reg          (iwrite_reg),
        .iread_from_ram      (iread_from_ram),
        .ialu_result         (ialu_result),
        .ipc_plus4           (ipc_plus4),
        .oready              (oready),
        .oregfile_we         (oregfile_we),
        .owrite_reg          (owrite_reg),
        .odata2write2regfile (odata2write2regfile),
        .omisaligned         (omisaligned),
        .oretired            (oretired)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [1:0] size, input logic uns);
`ifdef WB_SUBWORD_EN
        logic [31:0] b, h;
        b = (word >> (8 * addr[1:0])) & 32'hFF;
        h = (word >> (16 * addr[1])) & 32'hFFFF;
        if (size == 2'b00) return (uns || b < 32'h80)   ? b : b - 32'h100;
        if (size == 2'b01) return (uns || h < 32'h8000) ? h : h - 32'h10000;
        return word;
`else
        return word;
`endif
    endfunction

    function automatic bit ref_misaligned(input logic mtr, input logic [31:0] addr,
                                          input logic [1:0] size);
        int bytes;
`ifdef WB_SUBWORD_EN
        bytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
`else
        bytes = 4;
`endif
        return mtr && ((addr % bytes) != 0);
    endfunction

    // Apply the inputs present at a clock edge to the reference model.
    task automatic model_step();
        if (m_writes_left > 0) m_writes_left--;
        if (iflush) begin
            m_valid       = 1'b0;
            m_writes_left = 0;
        end else if (ihold) begin
            // entry stays put; its one write opportunity has been used
        end else if (ivalid) begin
            m_valid       = 1'b1;
            m_writes_left = 1;
            m_wr          = iSig_regfile_write;
            m_reg         = iwrite_reg;
            m_mis         = ref_misaligned(iSig_MemtoReg, ialu_result, iload_size);
            m_data        = iSig_Link     ? ipc_plus4 :
                            iSig_MemtoReg ? ref_load(iread_from_ram, ialu_result, iload_size, iload_unsigned) :
                                            ialu_result;
            if (!m_mis) m_retired = m_retired + 1;
        end else begin
            m_valid       = 1'b0;
            m_writes_left = 0;
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_writes_left = 0; m_wr = 0; m_mis = 0;
        m_reg = '0; m_data = '0; m_retired = '0;
    endtask

    task automatic compare_all();
        check("we",      oregfile_we, m_valid && m_writes_left > 0 && m_wr && m_reg != 0 && !m_mis);
        check("reg",     owrite_reg, m_reg);
        check("data",    odata2write2regfile, m_data);
        check("mis",     omisaligned, m_valid && m_mis);
        check("retired", oretired, m_retired);
        check("ready",   oready, !ihold);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic v, input logic h, input logic f, input logic w,
                         input logic mtr, input logic lnk, input logic [1:0] sz,
                         input logic u, input logic [4:0] rd, input logic [31:0] ram,
                         input logic [31:0] alu, input logic [31:0] pc4);
        ivalid = v; ihold = h; iflush = f; iSig_regfile_write = w;
        iSig_MemtoReg = mtr; iSig_Link = lnk; iload_size = sz; iload_unsigned = u;
        iwrite_reg = rd; iread_from_ram = ram; ialu_result = alu; ipc_plus4 = pc4;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 2'b10, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        rstn = 1'b0;
        idle();
        model_reset();
        #3;
        check("rst_we",      oregfile_we, 1'b0);
        check("rst_data",    odata2write2regfile, 32'h0);
        check("rst_retired", oretired, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // ALU op to r5
        drive(1, 0, 0, 1, 0, 0, 2'b10, 0, 5'd5, 32'hAAAA_5555, 32'h1234, 32'h8);
        tick();
        check("alu_we",   oregfile_we, 1'b1);
        check("alu_reg",  owrite_reg, 5'd5);
        check("alu_data", odata2write2regfile, 32'h1234);
        check("alu_ret",  oretired, 32'd1);
        idle();
        tick();
        check("alu_we_once", oregfile_we, 1'b0);

        // write to $0: no strobe, still retires
        drive(1, 0, 0, 1, 0, 0, 2'b10, 0, 5'd0, 32'h0, 32'h99, 32'h4);
        tick();
        check("r0_we",  oregfile_we, 1'b0);
        check("r0_ret", oretired, 32'd2);

        // link wins over RAM and ALU
        drive(1, 0, 0, 1, 1, 1, 2'b10, 0, 5'd31, 32'hDEAD_BEEF, 32'h100, 32'h40);
        tick();
        check("link_data", odata2write2regfile, 32'h40);
        check("link_we",   oregfile_we, 1'b1);

        // capture r7 then hold three cycles
        drive(1, 0, 0, 1, 0, 0, 2'b10, 0, 5'd7, 32'h0, 32'h77, 32'h0);
        tick();
        check("hold_first_we", oregfile_we, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 1, 0, 0, 2'b10, 0, 5'd9, 32'h0, 32'h99, 32'h0);
            #1;
            check("hold_ready", oready, 1'b0);
            tick();
            check("hold_we",  oregfile_we, 1'b0);
            check("hold_reg", owrite_reg, 5'd7);
        end
        check("hold_ret", oretired, 32'd4);
        idle();
        tick();

        // flush and hold together with a valid instruction
        drive(1, 1, 1, 1, 0, 0, 2'b10, 0, 5'd3, 32'h0, 32'h33, 32'h0);
        tick();
        check("flush_we",  oregfile_we, 1'b0);
        check("flush_ret", oretired, 32'd4);

        // aligned word load
        drive(1, 0, 0, 1, 1, 0, 2'b10, 0, 5'd4, 32'h80FF_7F01, 32'h0, 32'h0);
        tick();
        check("lw_data", odata2write2regfile, 32'h80FF_7F01);

        // misaligned word load
        drive(1, 0, 0, 1, 1, 0, 2'b10, 0, 5'd4, 32'h80FF_7F01, 32'h2, 32'h0);
        tick();
        check("lw_mis",    omisaligned, 1'b1);
        check("lw_mis_we", oregfile_we, 1'b0);
        check("lw_mis_ret", oretired, 32'd5);

`ifdef WB_SUBWORD_EN
        drive(1, 0, 0, 1, 1, 0, 2'b00, 0, 5'd4, 32'h80FF_7F01, 32'h3, 32'h0);
        tick();
        check("lb3", odata2write2regfile, 32'hFFFF_FF80);
        drive(1, 0, 0, 1, 1, 0, 2'b01, 1, 5'd4, 32'h80FF_7F01, 32'h2, 32'h0);
        tick();
        check("lhu2", odata2write2regfile, 32'h0000_80FF);
        drive(1, 0, 0, 1, 1, 0, 2'b00, 1, 5'd4, 32'h80FF_7F01, 32'h1, 32'h0);
        tick();
        check("lbu1", odata2write2regfile, 32'h0000_007F);
`endif

        // asynchronous reset while a write is on the port
        drive(1, 0, 0, 1, 0, 0, 2'b10, 0, 5'd6, 32'h0, 32'h66, 32'h0);
        tick();
        check("pre_rst_we", oregfile_we, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check("arst_we",   oregfile_we, 1'b0);
        check("arst_reg",  owrite_reg, 5'd0);
        check("arst_data", odata2write2regfile, 32'h0);
        check("arst_mis",  omisaligned, 1'b0);
        idle();
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check("arst_ret", oretired, 32'd0);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(1, 0) == 1) a[1:0] = 2'b00;
            drive($urandom_range(99, 0) < 80, $urandom_range(99, 0) < 20,
                  $urandom_range(99, 0) < 8, $urandom_range(1, 0) == 1,
                  $urandom_range(1, 0) == 1, $urandom_range(3, 0) == 0,
                  2'($urandom_range(3, 0)), $urandom_range(1, 0) == 1,
                  5'($urandom_range(31, 0)), $urandom, a, $urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
